// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encoding and
// requester port indices.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request wins outright, and under
// contention the port that was not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == PORT_LOADER) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU data port and a loader/debug port onto one single-port RAM
// with a fixed IDLE -> ACCESS -> DONE sequence per transaction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       ack,
    output logic [1:0]       err,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] ram_address,
    output logic             ram_read_en,
    output logic             ram_write_en,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_out
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    logic [1:0]       state_reg;
    logic             winner_reg;
    logic             last_reg;
    logic             we_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [1:0]       ack_reg;
    logic [1:0]       err_reg;
    logic [WIDTH-1:0] rdata_reg;

    logic [1:0]       grant;
    logic             winner_next;
    logic [1:0]       winner_onehot;
    logic             in_range;
    logic             in_access;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_reg),
        .grant (grant)
    );

    assign winner_next = grant[PORT_LOADER] ? PORT_LOADER : PORT_CPU;
    assign in_range    = (addr_reg < DEPTH_W);
    assign in_access   = (state_reg == ST_ACCESS);

    for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
        assign winner_onehot[gi] = (winner_reg == 1'(gi));
    end

    // Enables are gated by reset so a reset landing in ACCESS never commits a write.
    assign ram_read_en  = in_access && !we_reg && in_range && !reset;
    assign ram_write_en = in_access &&  we_reg && in_range && !reset;
    assign ram_address  = in_access ? addr_reg  : '0;
    assign ram_data_in  = in_access ? wdata_reg : '0;

    assign ack   = ack_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            winner_reg <= PORT_CPU;
            last_reg   <= PORT_LOADER;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            ack_reg    <= 2'b00;
            err_reg    <= 2'b00;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ack_reg <= 2'b00;
                    err_reg <= 2'b00;
                    if (|req) begin
                        winner_reg <= winner_next;
                        last_reg   <= winner_next;
                        we_reg     <= we[winner_next];
                        addr_reg   <= (winner_next == PORT_LOADER) ? addr1  : addr0;
                        wdata_reg  <= (winner_next == PORT_LOADER) ? wdata1 : wdata0;
                        state_reg  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ack_reg   <= winner_onehot;
                    err_reg   <= in_range ? 2'b00 : winner_onehot;
                    if (!we_reg) begin
                        rdata_reg <= in_range ? ram_out : '0;
                    end
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    ack_reg   <= 2'b00;
                    err_reg   <= 2'b00;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    ack_reg   <= 2'b00;
                    err_reg   <= 2'b00;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 32-word behavioural RAM attached.
module tb_mem_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [1:0]   we;
    logic [W-1:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]   ack, err;
    logic [W-1:0] rdata, ram_address, ram_data_in, ram_out;
    logic         ram_read_en, ram_write_en;

    logic [W-1:0] mem [0:31];
    logic         bd_we = 1'b0;
    logic [4:0]   bd_addr = '0;
    logic [W-1:0] bd_data = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .DEPTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .ram_address  (ram_address),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_data_in  (ram_data_in),
        .ram_out      (ram_out)
    );

    assign ram_out = (ram_address < 64'd32) ? mem[ram_address[4:0]] : '0;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address[4:0]] <= ram_data_in;
        else if (bd_we)   mem[bd_addr] <= bd_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [W-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    // Presents one request from IDLE and watches the bus until ack or timeout.
    // addr_late replaces the port address right after acceptance.
    task automatic do_txn(input int p, input logic w, input logic [W-1:0] a,
                          input logic [W-1:0] d, input logic [W-1:0] addr_late,
                          output int lat, output int rd_cnt, output int wr_cnt,
                          output logic [W-1:0] seen_addr, output logic [W-1:0] seen_wdata,
                          output logic [1:0] ack_seen, output logic [1:0] err_seen,
                          output logic [W-1:0] rdata_seen);
        lat = -1; rd_cnt = 0; wr_cnt = 0; seen_addr = '1; seen_wdata = '1;
        ack_seen = 2'b00; err_seen = 2'b00; rdata_seen = '1;
        req[p] = 1'b1; we[p] = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                if (p == 0) addr0 = addr_late; else addr1 = addr_late;
            end
            if (ram_read_en)  begin rd_cnt++; seen_addr = ram_address; end
            if (ram_write_en) begin wr_cnt++; seen_addr = ram_address; seen_wdata = ram_data_in; end
            if (ack != 2'b00) begin
                lat = c; ack_seen = ack; err_seen = err; rdata_seen = rdata;
                break;
            end
        end
        req[p] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        vectors++; if (ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack got %b want 00", ack); end
        vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", err); end
        vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
        vectors++; if ({ram_read_en, ram_write_en} !== 2'b00) begin miscompares++; $display("FAIL reset_en got %b want 00", {ram_read_en, ram_write_en}); end
        vectors++; if (ram_address !== '0 || ram_data_in !== '0) begin miscompares++; $display("FAIL reset_bus got addr=%h din=%h want 0/0", ram_address, ram_data_in); end
        $display("reset: ack=%b err=%b rdata=%h", ack, err, rdata);
    endtask

    task automatic test_single_read();
        int lat, rd, wr; logic [W-1:0] sa, sw, rd_v; logic [1:0] ak, er;
        preload(5'd5, 64'd500);
        do_txn(0, 1'b0, 64'd5, 64'd0, 64'd5, lat, rd, wr, sa, sw, ak, er, rd_v);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL read_latency got %0d want 2", lat); end
        vectors++; if (rd !== 1 || wr !== 0) begin miscompares++; $display("FAIL read_enables got rd=%0d wr=%0d want 1/0", rd, wr); end
        vectors++; if (sa !== 64'd5) begin miscompares++; $display("FAIL read_addr got %0d want 5", sa); end
        vectors++; if (ak !== 2'b01 || er !== 2'b00) begin miscompares++; $display("FAIL read_ack got ack=%b err=%b want 01/00", ak, er); end
        vectors++; if (rd_v !== 64'd500) begin miscompares++; $display("FAIL read_data got %0d want 500", rd_v); end
        $display("single_read: lat=%0d ack=%b rdata=%0d", lat, ak, rd_v);
    endtask

    task automatic test_write_read();
        int lat, rd, wr; logic [W-1:0] sa, sw, rd_v; logic [1:0] ak, er;
        do_txn(1, 1'b1, 64'd7, 64'hDEAD, 64'd7, lat, rd, wr, sa, sw, ak, er, rd_v);
        vectors++; if (wr !== 1 || rd !== 0) begin miscompares++; $display("FAIL write_enables got rd=%0d wr=%0d want 0/1", rd, wr); end
        vectors++; if (sa !== 64'd7 || sw !== 64'hDEAD) begin miscompares++; $display("FAIL write_bus got addr=%0d din=%h want 7/dead", sa, sw); end
        vectors++; if (ak !== 2'b10) begin miscompares++; $display("FAIL write_ack got %b want 10", ak); end
        vectors++; if (mem[7] !== 64'hDEAD) begin miscompares++; $display("FAIL write_mem got %h want dead", mem[7]); end
        $display("write: ack=%b mem7=%h", ak, mem[7]);
        do_txn(1, 1'b0, 64'd7, 64'd0, 64'd7, lat, rd, wr, sa, sw, ak, er, rd_v);
        vectors++; if (ak !== 2'b10 || rd_v !== 64'hDEAD) begin miscompares++; $display("FAIL readback got ack=%b rdata=%h want 10/dead", ak, rd_v); end
        $display("readback: ack=%b rdata=%h", ak, rd_v);
    endtask

    task automatic test_out_of_range();
        int lat, rd, wr; logic [W-1:0] sa, sw, rd_v; logic [1:0] ak, er;
        do_txn(0, 1'b0, 64'd32, 64'd0, 64'd32, lat, rd, wr, sa, sw, ak, er, rd_v);
        vectors++; if (rd !== 0 || wr !== 0) begin miscompares++; $display("FAIL oor_enables got rd=%0d wr=%0d want 0/0", rd, wr); end
        vectors++; if (ak !== 2'b01 || er !== 2'b01) begin miscompares++; $display("FAIL oor_ack got ack=%b err=%b want 01/01", ak, er); end
        vectors++; if (rd_v !== '0) begin miscompares++; $display("FAIL oor_rdata got %h want 0", rd_v); end
        vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL oor_err_pulse got %b want 00", err); end
        $display("out_of_range: ack=%b err=%b rdata=%h", ak, er, rd_v);
    endtask

    task automatic test_input_change();
        int lat, rd, wr; logic [W-1:0] sa, sw, rd_v; logic [1:0] ak, er;
        preload(5'd4, 64'd44);
        preload(5'd9, 64'd99);
        do_txn(0, 1'b0, 64'd4, 64'd0, 64'd9, lat, rd, wr, sa, sw, ak, er, rd_v);
        vectors++; if (sa !== 64'd4) begin miscompares++; $display("FAIL latch_addr got %0d want 4", sa); end
        vectors++; if (rd_v !== 64'd44) begin miscompares++; $display("FAIL latch_rdata got %0d want 44", rd_v); end
        $display("input_change: addr=%0d rdata=%0d", sa, rd_v);
    endtask

    task automatic test_contention();
        int n_ack; int exp_cyc [4]; logic [1:0] exp_ack [4]; logic [W-1:0] exp_dat [4];
        exp_cyc = '{2, 5, 8, 11};
        exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_dat = '{64'd111, 64'd222, 64'd111, 64'd222};
        preload(5'd1, 64'd111);
        preload(5'd2, 64'd222);
        reset = 1'b1; req = 2'b11; we = 2'b00; addr0 = 64'd1; addr1 = 64'd2;
        tick();
        reset = 1'b0;
        n_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ack != 2'b00) begin
                if (n_ack < 4) begin
                    vectors++;
                    if (c !== exp_cyc[n_ack] || ack !== exp_ack[n_ack] || rdata !== exp_dat[n_ack]) begin
                        miscompares++;
                        $display("FAIL contention_%0d got cyc=%0d ack=%b rdata=%0d want cyc=%0d ack=%b rdata=%0d",
                                 n_ack, c, ack, rdata, exp_cyc[n_ack], exp_ack[n_ack], exp_dat[n_ack]);
                    end
                    $display("contention: cycle=%0d ack=%b rdata=%0d", c, ack, rdata);
                end
                n_ack++;
            end
        end
        vectors++; if (n_ack !== 4) begin miscompares++; $display("FAIL contention_count got %0d want 4", n_ack); end
        req = 2'b00;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_write();
        preload(5'd3, 64'd333);
        req = 2'b01; we = 2'b01; addr0 = 64'd3; wdata0 = 64'd77;
        tick();
        vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("FAIL midwr_access got wen=%b want 1", ram_write_en); end
        reset = 1'b1;
        #1;
        vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL midwr_gate got wen=%b want 0", ram_write_en); end
        tick();
        reset = 1'b0; req = 2'b00; we = 2'b00;
        vectors++; if (ack !== 2'b00 || err !== 2'b00 || ram_address !== '0) begin miscompares++; $display("FAIL midwr_idle got ack=%b err=%b addr=%0d want 00/00/0", ack, err, ram_address); end
        tick();
        vectors++; if (ack !== 2'b00) begin miscompares++; $display("FAIL midwr_noack got %b want 00", ack); end
        vectors++; if (mem[3] !== 64'd333) begin miscompares++; $display("FAIL midwr_mem got %0d want 333", mem[3]); end
        req = 2'b11; addr0 = 64'd1; addr1 = 64'd2;
        tick(); tick();
        vectors++; if (ack !== 2'b01) begin miscompares++; $display("FAIL midwr_next_winner got %b want 01", ack); end
        $display("reset_mid_write: mem3=%0d next_ack=%b", mem[3], ack);
        req = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_out_of_range();
        test_input_change();
        test_contention();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
